// File: rtl/crc8_frame_ctrl.sv
// Frame buffer and bit-serialiser in front of an external CRC-8 engine.
// Buffers one frame, streams it MSB-first to the engine, and holds the remainder until taken.
module crc8_frame_ctrl #(
  parameter int unsigned MAX_BYTES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       crc_bit,
  output logic       crc_rst,
  input  logic [7:0] crc_msg,
  output logic [7:0] out_crc,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(MAX_BYTES + 1);
  localparam int unsigned IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

  typedef enum logic [1:0] {LOAD, SHIFT, OUT, DROP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] byte_q, byte_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       out_crc_q, out_crc_d;
  logic             out_valid_q, out_valid_d;
  logic             overflow_q, overflow_d;
  logic             crc_rst_q, crc_rst_d;
  logic             crc_bit_q, crc_bit_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             accept;
  logic             wr_en;
  logic [7:0]       buf_q [MAX_BYTES];

  assign accept = in_valid && in_ready_q;

  // Next-state, buffer write and serial-bit selection
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    byte_d      = byte_q;
    bit_d       = bit_q;
    out_crc_d   = out_crc_q;
    out_valid_d = out_valid_q;
    overflow_d  = 1'b0;
    crc_bit_d   = 1'b0;
    wr_en       = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (accept) begin
          if (count_q == CNT_W'(MAX_BYTES)) begin
            overflow_d = 1'b1;
            count_d    = '0;
            if (!in_last) state_d = DROP;
          end else begin
            wr_en   = 1'b1;
            count_d = count_q + CNT_W'(1);
            if (in_last) begin
              state_d = SHIFT;
              byte_d  = '0;
              bit_d   = 3'd0;
              // byte 0 may be the one being written on this very edge
              crc_bit_d = (count_q == '0) ? in_data[7] : buf_q[0][7];
            end
          end
        end
      end
      SHIFT: begin
        if (bit_q == 3'd7 && byte_q == IDX_W'(count_q - CNT_W'(1))) begin
          state_d     = OUT;
          out_crc_d   = crc_msg;
          out_valid_d = 1'b1;
          count_d     = '0;
        end else if (bit_q == 3'd7) begin
          byte_d    = byte_q + IDX_W'(1);
          bit_d     = 3'd0;
          crc_bit_d = buf_q[byte_q + IDX_W'(1)][7];
        end else begin
          bit_d     = bit_q + 3'd1;
          crc_bit_d = buf_q[byte_q][3'(~(bit_q + 3'd1))];
        end
      end
      OUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = LOAD;
        end
      end
      DROP: begin
        if (accept && in_last) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
    crc_rst_d  = (state_d == SHIFT);
    in_ready_d = (state_d == LOAD) || (state_d == DROP);
    busy_d     = (state_d != LOAD) || (count_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= LOAD;
      count_q     <= '0;
      byte_q      <= '0;
      bit_q       <= 3'd0;
      out_crc_q   <= 8'h00;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      crc_rst_q   <= 1'b0;
      crc_bit_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      byte_q      <= byte_d;
      bit_q       <= bit_d;
      out_crc_q   <= out_crc_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
      crc_rst_q   <= crc_rst_d;
      crc_bit_q   <= crc_bit_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Payload storage carries no reset; count_q alone defines valid contents
  always_ff @(posedge clk) begin
    if (wr_en) buf_q[IDX_W'(count_q)] <= in_data;
  end

  assign in_ready  = in_ready_q;
  assign crc_bit   = crc_bit_q;
  assign crc_rst   = crc_rst_q;
  assign out_crc   = out_crc_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_crc8_frame_ctrl.sv
// Directed bench for crc8_frame_ctrl with a behavioural CRC-8 (poly 0x07) engine
// that samples crc_bit on the falling edge.
module tb_crc8_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       crc_bit;
  logic       crc_rst;
  logic [7:0] crc_msg;
  logic [7:0] out_crc;
  logic       out_valid;
  logic       out_ready;
  logic       overflow;
  logic       busy;

  int vec  = 0;
  int errs = 0;
  logic [7:0] fr [0:31];
  logic [7:0] eng_q = 8'h00;

  crc8_frame_ctrl #(.MAX_BYTES(16)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .crc_bit(crc_bit), .crc_rst(crc_rst),
    .crc_msg(crc_msg), .out_crc(out_crc), .out_valid(out_valid),
    .out_ready(out_ready), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // External engine: cleared while crc_rst is low, shifts one bit mid-cycle otherwise
  always @(negedge clk) begin
    if (!crc_rst) eng_q <= 8'h00;
    else eng_q <= {eng_q[6:0], 1'b0} ^ ((eng_q[7] ^ crc_bit) ? 8'h07 : 8'h00);
  end
  assign crc_msg = eng_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = fr[i];
      in_last  = (i == n - 1);
      vec++;
      if (in_ready !== 1'b1) begin
        errs++;
        $display("FAIL send_ready byte %0d: got %b want 1", i, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(input int exp_lat, input logic [7:0] exp_crc);
    int cnt;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 300) begin
      tick();
      cnt++;
    end
    vec++;
    if (cnt != exp_lat) begin
      errs++;
      $display("FAIL latency: got %0d edges want %0d", cnt, exp_lat);
    end
    vec++;
    if (out_crc !== exp_crc) begin
      errs++;
      $display("FAIL out_crc: got %h want %h", out_crc, exp_crc);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL handshake: out_valid=%b in_ready=%b busy=%b want 0 1 0",
               out_valid, in_ready, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_data = 8'h00; in_valid = 1'b1; in_last = 1'b1; out_ready = 1'b0;
    #2;
    vec++;
    if ({in_ready, out_valid, crc_rst, crc_bit, overflow, busy} !== 6'b0 || out_crc !== 8'h00) begin
      errs++;
      $display("FAIL reset_values: rdy=%b ov=%b rst=%b bit=%b ovf=%b busy=%b crc=%h want all 0",
               in_ready, out_valid, crc_rst, crc_bit, overflow, busy, out_crc);
    end
    tick(); tick();
    vec++;
    if (in_ready !== 1'b0 || busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_held: in_ready=%b busy=%b want 0 0", in_ready, busy);
    end
    in_valid = 1'b0; in_last = 1'b0;
    reset = 1'b1;
    #2;
    vec++;
    if (in_ready !== 1'b0) begin
      errs++;
      $display("FAIL ready_before_edge: got %b want 0", in_ready);
    end
    tick();
    vec++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errs++;
      $display("FAIL ready_after_release: in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_single_byte();
    logic [7:0] exp_bits;
    exp_bits = 8'h01;
    fr[0] = 8'h01;
    send_frame(1);
    for (int k = 0; k < 8; k++) begin
      vec++;
      if (crc_rst !== 1'b1 || crc_bit !== exp_bits[7-k] || in_ready !== 1'b0 ||
          out_valid !== 1'b0 || busy !== 1'b1) begin
        errs++;
        $display("FAIL shift_cycle %0d: rst=%b bit=%b rdy=%b ov=%b busy=%b want 1 %b 0 0 1",
                 k, crc_rst, crc_bit, in_ready, out_valid, busy, exp_bits[7-k]);
      end
      tick();
    end
    vec++;
    if (out_valid !== 1'b1 || out_crc !== 8'h07 || crc_rst !== 1'b0 || crc_bit !== 1'b0) begin
      errs++;
      $display("FAIL single_result: ov=%b crc=%h rst=%b bit=%b want 1 07 0 0",
               out_valid, out_crc, crc_rst, crc_bit);
    end
    handshake();
  endtask

  task automatic test_check_string();
    for (int i = 0; i < 9; i++) fr[i] = 8'h31 + 8'(i);
    send_frame(9);
    vec++;
    if (busy !== 1'b1 || crc_rst !== 1'b1) begin
      errs++;
      $display("FAIL check_shift_start: busy=%b crc_rst=%b want 1 1", busy, crc_rst);
    end
    wait_out(72, 8'hF4);
    handshake();
  endtask

  task automatic test_back_to_back();
    fr[0] = 8'h01; fr[1] = 8'h00;
    send_frame(2);
    wait_out(16, 8'h15);
    handshake();
  endtask

  task automatic test_overflow();
    // 17 bytes with last on the 17th: pulse, then straight back to LOAD
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_data = 8'(i); in_last = (i == 16);
      tick();
      vec++;
      if (overflow !== (i == 16)) begin
        errs++;
        $display("FAIL ovf_pulse byte %0d: got %b want %b", i, overflow, (i == 16));
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    vec++;
    if (overflow !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL ovf_after: ovf=%b rdy=%b busy=%b ov=%b want 0 1 0 0",
               overflow, in_ready, busy, out_valid);
    end
    // 19 bytes, last on 19th: DROP absorbs bytes 18 and 19
    for (int i = 0; i < 19; i++) begin
      in_valid = 1'b1; in_data = 8'hA0; in_last = (i == 18);
      tick();
      vec++;
      if (overflow !== (i == 16) || in_ready !== 1'b1 || busy !== (i >= 0 && i < 18)) begin
        errs++;
        $display("FAIL drop byte %0d: ovf=%b rdy=%b busy=%b want %b 1 %b",
                 i, overflow, in_ready, busy, (i == 16), (i < 18));
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vec++;
      if (out_valid !== 1'b0 || overflow !== 1'b0) begin
        errs++;
        $display("FAIL drop_quiet: ov=%b ovf=%b want 0 0", out_valid, overflow);
      end
    end
    fr[0] = 8'h00;
    send_frame(1);
    wait_out(8, 8'h00);
    handshake();
  endtask

  task automatic test_out_backpressure();
    fr[0] = 8'h01;
    send_frame(1);
    wait_out(8, 8'h07);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = 8'(i); in_last = 1'b1;
      tick();
      vec++;
      if (out_valid !== 1'b1 || out_crc !== 8'h07 || in_ready !== 1'b0 || busy !== 1'b1) begin
        errs++;
        $display("FAIL hold cycle %0d: ov=%b crc=%h rdy=%b busy=%b want 1 07 0 1",
                 i, out_valid, out_crc, in_ready, busy);
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    handshake();
  endtask

  task automatic test_reset_mid_shift();
    fr[0] = 8'hFF;
    send_frame(1);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b0;
    #1;
    vec++;
    if (crc_rst !== 1'b0 || crc_bit !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 ||
        busy !== 1'b0) begin
      errs++;
      $display("FAIL mid_reset: rst=%b bit=%b ov=%b rdy=%b busy=%b want all 0",
               crc_rst, crc_bit, out_valid, in_ready, busy);
    end
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      vec++;
      if (out_valid !== 1'b0 || crc_rst !== 1'b0 || in_ready !== 1'b1) begin
        errs++;
        $display("FAIL post_reset cycle %0d: ov=%b rst=%b rdy=%b want 0 0 1",
                 i, out_valid, crc_rst, in_ready);
      end
    end
    fr[0] = 8'h01;
    send_frame(1);
    wait_out(8, 8'h07);
    handshake();
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_check_string();
    test_back_to_back();
    test_overflow();
    test_out_backpressure();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
